// File: rtl/uart_tx_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_arb : two-requester round-robin arbiter feeding a single uart_tx,
//               with per-requester holding buffers and a byte timeout.
// Revision    : 1.0
// ---------------------------------------------------------------------------
module uart_tx_arb #(
  parameter int unsigned TMO_CYCLES = 60000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_vld,
  input  logic [7:0] req0_data,
  output logic       req0_rdy,
  input  logic       req1_vld,
  input  logic [7:0] req1_data,
  output logic       req1_rdy,
  output logic       strt_tx,
  output logic [7:0] tx_data,
  input  logic       tx_done,
  output logic       grant,
  output logic       busy,
  output logic       tmo_err,
  input  logic       err_clr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TMO_CYCLES - 1);

  state_t      state;
  logic        full0;
  logic        full1;
  logic [7:0]  buf0;
  logic [7:0]  buf1;
  logic        last_grant;
  logic [15:0] tmo_cnt;
  logic        win;

  assign req0_rdy = ~full0;
  assign req1_rdy = ~full1;

  // On a tie the requester that did not go last wins.
  always_comb begin
    win = full1;
    if (full0 && full1) begin
      win = ~last_grant;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      full0      <= 1'b0;
      full1      <= 1'b0;
      buf0       <= 8'h00;
      buf1       <= 8'h00;
      last_grant <= 1'b1;
      tmo_cnt    <= 16'd0;
      strt_tx    <= 1'b0;
      tx_data    <= 8'h00;
      grant      <= 1'b0;
      busy       <= 1'b0;
      tmo_err    <= 1'b0;
    end else begin
      if (req0_vld && !full0) begin
        full0 <= 1'b1;
        buf0  <= req0_data;
      end
      if (req1_vld && !full1) begin
        full1 <= 1'b1;
        buf1  <= req1_data;
      end
      if (err_clr) begin
        tmo_err <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (full0 || full1) begin
            grant   <= win;
            tx_data <= win ? buf1 : buf0;
            strt_tx <= 1'b1;
            busy    <= 1'b1;
            tmo_cnt <= 16'd0;
            state   <= SEND;
          end
        end
        SEND: begin
          // tx_done may still be high from the previous byte; ignore it here.
          strt_tx <= 1'b0;
          tmo_cnt <= tmo_cnt + 16'd1;
          state   <= WAIT;
        end
        WAIT: begin
          if (tx_done || (tmo_cnt == TMO_LAST)) begin
            if (!tx_done) begin
              tmo_err <= 1'b1;
            end
            if (grant) begin
              full1 <= 1'b0;
            end else begin
              full0 <= 1'b0;
            end
            last_grant <= grant;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        default: begin
          strt_tx <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
